debouncer: RTL and testbench
============================

// Module: debouncer
// PURPOSE
//  Filters a noisy, asynchronous push-button level into a clean, glitch-free level.
//  Synchronises the input, then changes btn_out only after the new level has held for
//  STABLE_CYCLES consecutive clocks. Also emits one-cycle press/release strobes.
//  Sits between a board pin and control logic in the clk domain.
// PARAMETERS
//  SYNC_STAGES    2  synchroniser flop count on btn_in; legal range >=2
//  STABLE_CYCLES  4  consecutive agreeing samples required to change btn_out; legal range >=1
// PORTS
//  clk      in   1  system clock, rising-edge active
//  rst_n    in   1  asynchronous active-low reset
//  btn_in   in   1  raw button level, asynchronous to clk, may bounce
//  btn_out  out  1  debounced level, registered
//  btn_rise out  1  1-cycle strobe on the clock where btn_out goes 0->1
//  btn_fall out  1  1-cycle strobe on the clock where btn_out goes 1->0
// BEHAVIOUR
//  - One clock (clk); reset is asynchronous and active-low (rst_n).
//  - Reset: sync chain=0, counter=0, btn_out=0, btn_rise=0, btn_fall=0. Assertion takes
//    effect immediately with no clock. Deassertion is clean on the next clk edge.
//  - Synchroniser: btn_in shifts through SYNC_STAGES flops. s = last stage.
//  - Counter cnt, width $clog2(STABLE_CYCLES)+1, is evaluated on every clk edge:
//      s == btn_out                           : cnt<=0 (any bounce restarts the qualification)
//      s != btn_out, cnt <  STABLE_CYCLES-1   : cnt<=cnt+1
//      s != btn_out, cnt == STABLE_CYCLES-1   : btn_out<=s, cnt<=0
//  - btn_rise/btn_fall are registered. They are high for exactly the one cycle in which
//    the new btn_out value first appears; otherwise they are 0. They are never both high.
//  - Latency: with defaults, btn_in stable from sampling edge k gives btn_out change at
//    edge k+SYNC_STAGES+STABLE_CYCLES-1 (k+5).
//  - Pulse filtering: a level held for fewer than STABLE_CYCLES samples is discarded.
//    A level held for STABLE_CYCLES or more samples is accepted. Rising and falling
//    transitions are treated identically.
//  - The counter saturates by design: it cannot exceed STABLE_CYCLES-1, so there is no
//    wrap-around.
//  - A reset in the middle of qualification discards the count. After reset, btn_out
//    starts from 0 and re-qualifies if btn_in is held high.
//  - STABLE_CYCLES=1: btn_out follows s with a 1-clk register delay.
// STRUCTURE
//  - Sub-module btn_synchronizer (parameter SYNC_STAGES, ports clk, rst_n, d, q). It is
//    reusable for other async inputs.
//  - The counter and output logic stay in debouncer. No FSM beyond the btn_out state bit.
//  - No shared package is needed; widths derive locally via $clog2.
// TESTING (clk period 10, defaults)
//  1 Reset: rst_n=0 with btn_in=1 -> all outputs 0. Release, btn_in held 1 -> btn_out=1
//    and btn_rise=1 one cycle, 5 clks after release.
//  2 Glitch: btn_in=1 for 1 clk (t=20..30) -> btn_out stays 0, no strobes.
//  3 Short pulse: btn_in=1 for 3 clks (t=40..70) -> btn_out stays 0.
//  4 Valid press: btn_in=1 for 5 clks (t=80..130) -> btn_out 0->1 after 4 stable samples.
//    btn_rise pulses once. After btn_in=0 for >=4 clks, btn_out->0 and btn_fall pulses once.
//  5 Bouncy release: from btn_out=1, toggle btn_in 0/1 every clk for 10 clks, then hold 0
//    -> btn_out stays 1 until 4 consecutive low samples, then falls exactly once.
//  6 Async reset mid-qualification: assert rst_n=0 off-edge after 2 of 4 samples
//    -> btn_out=0 immediately and cnt restarts from 0 after release.

Source files
------------

// File: rtl/btn_synchronizer.sv
// Multi-flop synchroniser that brings an asynchronous level into the clk domain.
// Reusable for any slow asynchronous input, not only buttons.
module btn_synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/debouncer.sv
// Push-button debouncer: synchronise, then accept a new level only after it has
// been seen for STABLE_CYCLES consecutive clocks; emits one-cycle press/release strobes.
module debouncer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_out,
  output logic btn_rise,
  output logic btn_fall
);

  localparam int              CW       = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  logic          btn_s;
  logic [CW-1:0] cnt_q,  cnt_d;
  logic          out_q,  out_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  btn_synchronizer #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (btn_in),
    .q    (btn_s)
  );

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    cnt_d  = '0;
    out_d  = out_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (btn_s != out_q) begin
      if (cnt_q == CNT_LAST) begin
        // Candidate level has held long enough: commit it and strobe once.
        out_d  = btn_s;
        rise_d = btn_s;
        fall_d = ~btn_s;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // NOTE: only control state lives here, so all of it is reset; reset takes
  // effect asynchronously and the first functional edge follows release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      out_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign btn_out  = out_q;
  assign btn_rise = rise_q;
  assign btn_fall = fall_q;

endmodule

// File: tb/tb_debouncer.sv
// Bench for debouncer: a sample-history model checked every cycle, plus directed
// scenarios with hand-computed latencies and strobe counts.
module tb_debouncer;

  localparam int SYNC_STAGES   = 2;
  localparam int STABLE_CYCLES = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_in;
  logic btn_out, btn_rise, btn_fall;

  int checks = 0;
  int errors = 0;
  int n_rise = 0;
  int n_fall = 0;

  debouncer #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_in  (btn_in),
    .btn_out (btn_out),
    .btn_rise(btn_rise),
    .btn_fall(btn_fall)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Model: the filtered level flips once the delayed samples since the last
  // flip contain STABLE_CYCLES consecutive values that disagree with it.
  bit hist[$];
  bit shist[$];
  bit m_out, m_rise, m_fall, m_s, m_flip;
  int since;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      shist.delete();
      m_out = 1'b0; m_rise = 1'b0; m_fall = 1'b0; since = 0;
    end else begin
      m_s = (hist.size() >= SYNC_STAGES) ? hist[hist.size()-SYNC_STAGES] : 1'b0;
      hist.push_back(btn_in);
      shist.push_back(m_s);
      since++;
      m_flip = 1'b0;
      if (since >= STABLE_CYCLES) begin
        m_flip = 1'b1;
        for (int i = 0; i < STABLE_CYCLES; i++)
          if (shist[shist.size()-1-i] == m_out) m_flip = 1'b0;
      end
      m_rise = m_flip && !m_out;
      m_fall = m_flip && m_out;
      if (m_flip) begin
        m_out = ~m_out;
        since = 0;
      end
    end
  end

  // Per-cycle compare, sampled 2 time units after the active edge.
  always begin
    @(posedge clk);
    #2;
    if (!rst_n) begin
      check("rst_out",  btn_out,  1'b0);
      check("rst_rise", btn_rise, 1'b0);
      check("rst_fall", btn_fall, 1'b0);
    end else begin
      check("model_out",  btn_out,  m_out);
      check("model_rise", btn_rise, m_rise);
      check("model_fall", btn_fall, m_fall);
    end
    check("rise_fall_exclusive", btn_rise & btn_fall, 1'b0);
    if (btn_rise === 1'b1) n_rise++;
    if (btn_fall === 1'b1) n_fall++;
  end

  task automatic wait_edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  int r0, f0;

  initial begin
    // 1: reset with the button held, then qualify after release
    rst_n  = 1'b0;
    btn_in = 1'b1;
    wait_edges(3);
    check("t1_reset_out",  btn_out,  1'b0);
    check("t1_reset_rise", btn_rise, 1'b0);
    rst_n = 1'b1;
    wait_edges(5);
    check("t1_edge5_out", btn_out, 1'b0);
    wait_edges(1);
    check("t1_edge6_out",  btn_out,  1'b1);
    check("t1_edge6_rise", btn_rise, 1'b1);
    wait_edges(1);
    check("t1_edge7_rise", btn_rise, 1'b0);

    // Falling latency mirrors rising latency
    btn_in = 1'b0;
    wait_edges(5);
    check("t1_fall_edge5_out", btn_out, 1'b1);
    wait_edges(1);
    check("t1_fall_edge6_out",  btn_out,  1'b0);
    check("t1_fall_edge6_fall", btn_fall, 1'b1);
    wait_edges(4);

    // 2: single-clock glitch is discarded
    r0 = n_rise; f0 = n_fall;
    btn_in = 1'b1; wait_edges(1);
    btn_in = 1'b0; wait_edges(8);
    check("t2_glitch_out",   btn_out,               1'b0);
    check("t2_glitch_rises", (n_rise - r0) == 0,    1'b1);

    // 3: three-clock pulse (one short of qualifying) is discarded
    r0 = n_rise;
    btn_in = 1'b1; wait_edges(3);
    btn_in = 1'b0; wait_edges(8);
    check("t3_short_out",   btn_out,            1'b0);
    check("t3_short_rises", (n_rise - r0) == 0, 1'b1);

    // Boundary: exactly four samples is accepted, then released
    r0 = n_rise; f0 = n_fall;
    btn_in = 1'b1; wait_edges(4);
    btn_in = 1'b0; wait_edges(8);
    check("t3b_exact_rises", (n_rise - r0) == 1, 1'b1);
    check("t3b_exact_falls", (n_fall - f0) == 1, 1'b1);
    check("t3b_exact_out",   btn_out,            1'b0);

    // 4: valid five-clock press, then release
    r0 = n_rise; f0 = n_fall;
    btn_in = 1'b1; wait_edges(5);
    btn_in = 1'b0; wait_edges(1);
    check("t4_press_out",  btn_out,  1'b1);
    check("t4_press_rise", btn_rise, 1'b1);
    wait_edges(8);
    check("t4_release_out",   btn_out,            1'b0);
    check("t4_press_rises",   (n_rise - r0) == 1, 1'b1);
    check("t4_release_falls", (n_fall - f0) == 1, 1'b1);

    // 5: bouncy release from a settled high level
    btn_in = 1'b1; wait_edges(8);
    check("t5_settled_high", btn_out, 1'b1);
    f0 = n_fall;
    for (int i = 0; i < 10; i++) begin
      btn_in = i[0];
      wait_edges(1);
    end
    check("t5_bounce_holds", btn_out, 1'b1);
    btn_in = 1'b0; wait_edges(8);
    check("t5_bounce_out",   btn_out,            1'b0);
    check("t5_bounce_falls", (n_fall - f0) == 1, 1'b1);

    // 6: asynchronous reset midway through qualifying a release
    btn_in = 1'b1; wait_edges(8);
    check("t6_settled_high", btn_out, 1'b1);
    btn_in = 1'b0; wait_edges(4);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_out",  btn_out,  1'b0);
    check("t6_async_fall", btn_fall, 1'b0);
    btn_in = 1'b1;
    wait_edges(3);
    rst_n = 1'b1;
    wait_edges(5);
    check("t6_requal_edge5_out", btn_out, 1'b0);
    wait_edges(1);
    check("t6_requal_edge6_out",  btn_out,  1'b1);
    check("t6_requal_edge6_rise", btn_rise, 1'b1);
    wait_edges(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
